// File: rtl/seg7_if.sv
// Signal bundle between the port C producer and the 7-segment display driver.
// din/hex_mode are level signals with no valid/ready; the driver samples them whenever its FSM is idle.
interface seg7_if;
  logic [15:0] din;
  logic        hex_mode;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic        busy;
  logic [1:0]  state_dbg;

  modport master (output din, hex_mode, input seg, an, busy, state_dbg);
  modport slave  (input din, hex_mode, output seg, an, busy, state_dbg);
endinterface

// File: rtl/seg7_display_driver.sv
// 4-digit common-anode 7-segment driver: double-dabble decimal or raw hex,
// time-multiplexed scan, display image only replaced once a conversion completes.
module seg7_display_driver #(
  parameter int REFRESH_CYCLES = 100000,
  parameter int CNT_W          = 17
) (
  input logic   clk,
  input logic   reset,
  seg7_if.slave bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2} state_t;

  localparam logic [4:0] CODE_DASH  = 5'd16;
  localparam logic [4:0] CODE_BLANK = 5'd17;

  state_t           state, state_nxt;
  logic             busy;
  logic [16:0]      lat;
  logic             lat_valid;
  logic             start;
  logic [15:0]      bin;
  logic [19:0]      bcd;
  logic [19:0]      bcd_adj;
  logic [3:0]       iter;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       idx;
  logic [4:0]       digit [4];
  logic [6:0]       seg_q;
  logic [3:0]       an_q;

  function automatic logic [6:0] seg_decode(input logic [4:0] code);
    logic [6:0] s;
    case (code)
      5'd0:  s = 7'b1000000;
      5'd1:  s = 7'b1111001;
      5'd2:  s = 7'b0100100;
      5'd3:  s = 7'b0110000;
      5'd4:  s = 7'b0011001;
      5'd5:  s = 7'b0010010;
      5'd6:  s = 7'b0000010;
      5'd7:  s = 7'b1111000;
      5'd8:  s = 7'b0000000;
      5'd9:  s = 7'b0010000;
      5'd10: s = 7'b0001000;
      5'd11: s = 7'b0000011;
      5'd12: s = 7'b1000110;
      5'd13: s = 7'b0100001;
      5'd14: s = 7'b0000110;
      5'd15: s = 7'b0001110;
      5'd16: s = 7'b0111111;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  // A cleared lat_valid forces one conversion right after reset even if din is 0.
  assign start = (state == IDLE) && (!lat_valid || ({bus.hex_mode, bus.din} != lat));

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    case (state)
      IDLE:  if (start) state_nxt = bus.hex_mode ? DONE : SHIFT;
      SHIFT: begin
        busy = 1'b1;
        if (iter == 4'd15) state_nxt = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < 5; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lat       <= '0;
      lat_valid <= 1'b0;
      bin       <= '0;
      bcd       <= '0;
      iter      <= '0;
      for (int i = 0; i < 4; i++) digit[i] <= CODE_BLANK;
    end else begin
      if (start) begin
        lat       <= {bus.hex_mode, bus.din};
        lat_valid <= 1'b1;
        bin       <= bus.din;
        bcd       <= '0;
        iter      <= '0;
      end
      if (state == SHIFT) begin
        {bcd, bin} <= {bcd_adj[18:0], bin, 1'b0};
        iter       <= iter + 4'd1;
      end
      // The ten-thousands BCD column is nonzero exactly when the value exceeds 9999.
      if (state == DONE) begin
        if (lat[16]) begin
          for (int i = 0; i < 4; i++) digit[i] <= {1'b0, lat[4*i +: 4]};
        end else if (bcd[19:16] != 4'd0) begin
          for (int i = 0; i < 4; i++) digit[i] <= CODE_DASH;
        end else begin
          digit[0] <= {1'b0, bcd[3:0]};
          digit[1] <= (bcd[15:4]  == 12'd0) ? CODE_BLANK : {1'b0, bcd[7:4]};
          digit[2] <= (bcd[15:8]  == 8'd0)  ? CODE_BLANK : {1'b0, bcd[11:8]};
          digit[3] <= (bcd[15:12] == 4'd0)  ? CODE_BLANK : {1'b0, bcd[15:12]};
        end
      end
    end
  end

  // Scan free-runs regardless of the FSM; seg/an are registered from the current index.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt   <= '0;
      idx   <= '0;
      seg_q <= 7'b1111111;
      an_q  <= 4'b1111;
    end else begin
      if (cnt == CNT_W'(REFRESH_CYCLES - 1)) begin
        cnt <= '0;
        idx <= idx + 2'd1;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
      seg_q <= seg_decode(digit[idx]);
      an_q  <= ~(4'b0001 << idx);
    end
  end

  assign bus.seg       = seg_q;
  assign bus.an        = an_q;
  assign bus.busy      = busy;
  assign bus.state_dbg = state;
endmodule

// File: tb/tb_seg7_display_driver.sv
// Randomized bench for seg7_display_driver against an arithmetic model of the
// expected display image and the scan timing.
module tb_seg7_display_driver;
  localparam int RC = 4;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  seg7_if bus();

  seg7_display_driver #(.REFRESH_CYCLES(RC), .CNT_W(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int edge_k = 0;  // active edges since reset was released
  always @(posedge clk) begin
    if (reset) edge_k <= 0;
    else       edge_k <= edge_k + 1;
  end

  // ---------------- scoreboard ----------------
  int          n_checks = 0;
  int          n_errors = 0;
  logic [27:0] exp_q[$];
  logic [6:0]  seg_tab [18];
  logic        cur_hm;
  int          cur_v;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected 4-digit image from the display rules, digit i at bits [7i+6:7i].
  function automatic logic [27:0] model_image(input logic hm, input int v);
    logic [27:0] img;
    int p;
    img = '0;
    p   = 1;
    for (int i = 0; i < 4; i++) begin
      if (hm)                   img[7*i +: 7] = seg_tab[(v >> (4*i)) & 15];
      else if (v > 9999)        img[7*i +: 7] = seg_tab[16];
      else if (i > 0 && v < p)  img[7*i +: 7] = seg_tab[17];
      else                      img[7*i +: 7] = seg_tab[(v / p) % 10];
      p = p * 10;
    end
    return img;
  endfunction

  function automatic int scan_digit();
    return ((edge_k - 1) / RC) % 4;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic measure_busy(output int len);
    int w;
    len = 0;
    w   = 0;
    while (bus.busy !== 1'b1 && w < 6) begin
      @(negedge clk);
      w++;
    end
    while (bus.busy === 1'b1 && len < 40) begin
      @(negedge clk);
      len++;
    end
  endtask

  task automatic scan_check(input logic [27:0] img, input string tag);
    int d;
    logic [3:0] a;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      d = scan_digit();
      a = ~(4'b0001 << d);
      check_val({tag, "_an"}, 32'(bus.an), 32'(a));
      check_val({tag, "_seg"}, 32'(bus.seg), 32'(img[7*d +: 7]));
    end
  endtask

  task automatic apply(input logic hm, input int v, input string tag);
    int len;
    bus.hex_mode = hm;
    bus.din      = 16'(v);
    cur_hm       = hm;
    cur_v        = v;
    exp_q.push_back(model_image(hm, v));
    measure_busy(len);
    check_val({tag, "_busy_len"}, 32'(len), hm ? 32'd1 : 32'd17);
    scan_check(exp_q.pop_front(), tag);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int len, bad, busy_cnt, falls, v, sel;
    logic hm;
    logic [27:0] old_img, img_a, img_b;

    seg_tab[0]  = 7'b1000000; seg_tab[1]  = 7'b1111001; seg_tab[2]  = 7'b0100100;
    seg_tab[3]  = 7'b0110000; seg_tab[4]  = 7'b0011001; seg_tab[5]  = 7'b0010010;
    seg_tab[6]  = 7'b0000010; seg_tab[7]  = 7'b1111000; seg_tab[8]  = 7'b0000000;
    seg_tab[9]  = 7'b0010000; seg_tab[10] = 7'b0001000; seg_tab[11] = 7'b0000011;
    seg_tab[12] = 7'b1000110; seg_tab[13] = 7'b0100001; seg_tab[14] = 7'b0000110;
    seg_tab[15] = 7'b0001110; seg_tab[16] = 7'b0111111; seg_tab[17] = 7'b1111111;

    bus.din      = 16'd0;
    bus.hex_mode = 1'b0;
    cur_hm       = 1'b0;
    cur_v        = 0;

    repeat (3) @(negedge clk);
    check_val("rst_seg", 32'(bus.seg), 32'h7F);
    check_val("rst_an", 32'(bus.an), 32'hF);
    check_val("rst_busy", 32'(bus.busy), 32'd0);

    reset = 1'b0;
    measure_busy(len);
    check_val("post_rst_busy_len", 32'(len), 32'd17);
    scan_check(model_image(1'b0, 0), "zero");

    apply(1'b0, 1234,  "d1234");
    apply(1'b0, 10000, "d10000");
    apply(1'b0, 65535, "d65535");
    apply(1'b0, 9999,  "d9999");
    apply(1'b1, 16'hBEEF, "hBEEF");

    for (int n = 0; n < 12; n++) begin
      sel = $urandom_range(0, 3);
      case (sel)
        0:       v = $urandom_range(0, 99);
        1:       v = $urandom_range(0, 9999);
        2:       v = $urandom_range(9990, 10010);
        default: v = $urandom_range(0, 65535);
      endcase
      hm = ($urandom_range(0, 3) == 0);
      if (hm == cur_hm && v == cur_v) v = v ^ 1;
      apply(hm, v, "rand");
    end

    // din changes mid-conversion: only old, 1234 and 56 images may ever be shown
    apply(1'b0, 7, "pre_chg");
    old_img = model_image(1'b0, 7);
    img_a   = model_image(1'b0, 1234);
    img_b   = model_image(1'b0, 56);
    bus.din = 16'd1234;
    repeat (5) @(negedge clk);
    bus.din  = 16'd56;
    cur_v    = 56;
    busy_cnt = 5;
    falls    = 0;
    bad      = 0;
    for (int c = 0; c < 60 && falls < 2; c++) begin
      @(negedge clk);
      if (bus.seg !== old_img[7*scan_digit() +: 7] &&
          bus.seg !== img_a[7*scan_digit() +: 7] &&
          bus.seg !== img_b[7*scan_digit() +: 7]) bad++;
      if (falls == 1 && bus.busy === 1'b1 && busy_cnt == 17)
        check_val("chg_first_image", 32'(bus.seg), 32'(img_a[7*scan_digit() +: 7]));
      if (bus.busy === 1'b1) busy_cnt++;
      else falls++;
    end
    check_val("chg_busy_total", 32'(busy_cnt), 32'd34);
    check_val("chg_interim_images", 32'(bad), 32'd0);
    scan_check(img_b, "chg_final");

    // reset on cycle 8 of SHIFT
    v = $urandom_range(100, 9999);
    bus.din = 16'(v);
    cur_v   = v;
    @(negedge clk);
    check_val("mid_busy_start", 32'(bus.busy), 32'd1);
    repeat (7) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_val("mid_rst_seg", 32'(bus.seg), 32'h7F);
    check_val("mid_rst_an", 32'(bus.an), 32'hF);
    check_val("mid_rst_busy", 32'(bus.busy), 32'd0);
    reset = 1'b0;
    measure_busy(len);
    check_val("mid_rst_busy_len", 32'(len), 32'd17);
    scan_check(model_image(1'b0, v), "mid_rst");

    // ---------------- final report ----------------
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
